// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF-stage fetch unit with PC, imem req/ready port and 2-entry fetch FIFO
//
// Purpose: owns the PC, fetches words from instruction memory one request at a
// time, buffers up to two fetched words and presents the oldest to IF/ID.
//
// Ports:
//   Clk, Reset_n      clock (rising edge), asynchronous active-low reset
//   Stall             IF/ID holding; FIFO head is not consumed
//   Redirect          branch/jump taken (overrides Stall), target RedirectPC
//   IMemReq/IMemAddr  fetch request and word address, held until IMemReady
//   IMemReady         request completes this cycle, IMemRdata valid
//   IMemRdata         fetched instruction word
//   IFInstruction     FIFO head word (NOP_WORD when empty)
//   IFPCplus4         FIFO head PC+4 (0 when empty)
//   IFValid           FIFO non-empty
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRdata,
  output logic [31:0] IFInstruction,
  output logic [31:0] IFPCplus4,
  output logic        IFValid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target_pc;

  logic [31:0] fifo_ins [2];
  logic [31:0] fifo_pc4 [2];
  logic        rd_ptr;
  logic [1:0]  count;

  logic        consume;
  logic        push;
  logic [1:0]  occ_after;
  logic        space;
  logic        wr_idx;
  logic [31:0] redir_pc;
  logic [31:0] pc_plus4;

  assign consume   = IFValid & ~Stall & ~Redirect;
  assign occ_after = count - {1'b0, consume};
  assign space     = (occ_after < 2'd2);
  assign push      = (state == S_FETCH) & IMemReady & ~Redirect;
  // Tail slot: head + count (mod 2). With count==2 and a consume this is the
  // slot being vacated by the head, which is exactly where the new word goes.
  assign wr_idx    = rd_ptr ^ count[0];
  assign redir_pc  = RedirectPC & ~32'd3;
  assign pc_plus4  = pc + 32'd4;

  assign IFValid       = (count != 2'd0);
  assign IMemAddr      = pc;
  assign IFInstruction = IFValid ? fifo_ins[rd_ptr] : NOP_WORD;
  assign IFPCplus4     = IFValid ? fifo_pc4[rd_ptr] : 32'd0;

  // FIFO storage and occupancy. A redirect discards everything buffered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      fifo_ins[0] <= 32'd0;
      fifo_ins[1] <= 32'd0;
      fifo_pc4[0] <= 32'd0;
      fifo_pc4[1] <= 32'd0;
    end else if (Redirect) begin
      count <= 2'd0;
    end else begin
      if (push) begin
        fifo_ins[wr_idx] <= IMemRdata;
        fifo_pc4[wr_idx] <= pc_plus4;
      end
      rd_ptr <= rd_ptr ^ consume;
      count  <= occ_after + {1'b0, push};
    end
  end

  // Fetch control. IMemReq is registered alongside the state so it is high
  // exactly in FETCH and DISCARD.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      target_pc <= 32'd0;
      IMemReq   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Redirect) begin
            pc <= redir_pc;
          end else if (space) begin
            state   <= S_FETCH;
            IMemReq <= 1'b1;
          end
        end
        S_FETCH: begin
          if (IMemReady) begin
            if (Redirect) begin
              pc <= redir_pc;
            end else begin
              pc <= pc_plus4;
              // After this push the FIFO would be full: stop fetching.
              if (occ_after != 2'd0) begin
                state   <= S_IDLE;
                IMemReq <= 1'b0;
              end
            end
          end else if (Redirect) begin
            // The request must complete at its original address; remember
            // where to go once it does.
            target_pc <= redir_pc;
            state     <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (IMemReady) begin
            pc    <= Redirect ? redir_pc : target_pc;
            state <= S_FETCH;
          end else if (Redirect) begin
            target_pc <= redir_pc;
          end
        end
        default: begin
          state   <= S_IDLE;
          IMemReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
